// File: rtl/iod_train_pkg.sv
// Shared definitions for the IOD read-training sequencer.
//   state_t      : sequencer states
//   DEF_*        : default parameter values for the top level
//   WAIT_CNT_W   : width of the shared settle/sample wait counter
//   centre_tap() : floor centre of a window given its start and length
package iod_train_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CLEAR,
    ST_SAMPLE,
    ST_EVAL,
    ST_STEP,
    ST_CMOVE,
    ST_CSETTLE,
    ST_DONE
  } state_t;

  localparam int DEF_TAP_W         = 8;
  localparam int DEF_MAX_TAPS      = 128;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_SAMPLE_CYCLES = 16;
  localparam int DEF_MIN_WINDOW    = 4;
  localparam int WAIT_CNT_W        = 16;

  // Only meaningful for len >= 1; the caller never uses the result otherwise.
  function automatic int unsigned centre_tap(input int unsigned start,
                                             input int unsigned len);
    return start + ((len - 1) >> 1);
  endfunction

endpackage

// File: rtl/iod_train_wait_cnt.sv
// Loadable down-counter used for the SETTLE, SAMPLE and CSETTLE dwell times.
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset
//   load     : load load_val this cycle
//   load_val : dwell length minus one
//   tc       : terminal count, high while the count is zero
// Loading N-1 in the cycle before a wait state makes that state last N cycles.
module iod_train_wait_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/iod_read_training_ctrl.sv
// Per-lane read-training sequencer. Sweeps the IOD receive delay line tap by
// tap, samples the eye-monitor EARLY/LATE flags at each tap, finds the widest
// passing window (earliest wins ties) and parks the delay line at its centre.
// Ports:
//   FAB_CLK, RX_SYNC_RST      : clock, synchronous active-high reset
//   START                     : one-cycle request, honoured in IDLE or DONE
//   BUSY, DONE, FAIL          : status; FAIL/TAP_OUT/WIN_LEN valid with DONE
//   TAP_OUT, WIN_LEN          : final tap and best window width
//   DELAY_LINE_LOAD/MOVE/DIRECTION : delay-line controls (1 = increment)
//   EYE_MONITOR_CLEAR_FLAGS   : clear pulse before each sample window
//   EYE_MONITOR_EARLY/LATE    : eye-monitor flags
//   DELAY_LINE_OUT_OF_RANGE   : delay-line limit flag
// Optional (IOD_TRAIN_STATUS_EN): WIN_START, SWEEP_END, FAIL_TAPS.
module iod_read_training_ctrl
  import iod_train_pkg::*;
#(
  parameter int TAP_W         = DEF_TAP_W,
  parameter int MAX_TAPS      = DEF_MAX_TAPS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int MIN_WINDOW    = DEF_MIN_WINDOW
) (
  input  logic             FAB_CLK,
  input  logic             RX_SYNC_RST,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic [TAP_W-1:0] TAP_OUT,
  output logic [TAP_W:0]   WIN_LEN,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
`ifdef IOD_TRAIN_STATUS_EN
  output logic [TAP_W-1:0] WIN_START,
  output logic [TAP_W-1:0] SWEEP_END,
  output logic [15:0]      FAIL_TAPS,
`endif
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  input  logic             DELAY_LINE_OUT_OF_RANGE
);

  localparam logic [TAP_W-1:0]      LAST_TAP   = TAP_W'(MAX_TAPS - 1);
  localparam logic [TAP_W:0]        MIN_LEN    = (TAP_W + 1)'(MIN_WINDOW);
  localparam logic [WAIT_CNT_W-1:0] SETTLE_VAL = WAIT_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [WAIT_CNT_W-1:0] SAMPLE_VAL = WAIT_CNT_W'(SAMPLE_CYCLES - 1);

  state_t state, state_nxt;

  logic [TAP_W-1:0] cur_tap, cur_start, best_start, centre_q;
  logic [TAP_W:0]   cur_len, best_len;
  logic             sticky, oor_tap, fail_q;

  logic             pass;
  logic [TAP_W:0]   len_upd, best_len_upd;
  logic [TAP_W-1:0] start_upd, best_start_upd, centre_nxt;
  logic             sweep_last, win_ok, start_ok;

  logic                  wc_load, wc_tc;
  logic [WAIT_CNT_W-1:0] wc_val;

  iod_train_wait_cnt #(.CNT_W(WAIT_CNT_W)) u_wait_cnt (
    .clk      (FAB_CLK),
    .rst      (RX_SYNC_RST),
    .load     (wc_load),
    .load_val (wc_val),
    .tc       (wc_tc)
  );

  // Window bookkeeping as it will stand after this EVAL cycle. An
  // out-of-range tap always fails and also ends the sweep.
  always_comb begin
    pass           = !sticky && !oor_tap;
    len_upd        = pass ? cur_len + (TAP_W + 1)'(1) : '0;
    start_upd      = (pass && cur_len == '0) ? cur_tap : cur_start;
    best_len_upd   = best_len;
    best_start_upd = best_start;
    if (len_upd > best_len) begin
      best_len_upd   = len_upd;
      best_start_upd = start_upd;
    end
    sweep_last = oor_tap || (cur_tap == LAST_TAP);
    win_ok     = (best_len_upd >= MIN_LEN);
    centre_nxt = TAP_W'(centre_tap(32'(best_start_upd), 32'(best_len_upd)));
  end

  assign start_ok = START && (state == ST_IDLE || state == ST_DONE);

  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt               = state;
    DELAY_LINE_LOAD         = 1'b0;
    DELAY_LINE_MOVE         = 1'b0;
    DELAY_LINE_DIRECTION    = 1'b1;
    EYE_MONITOR_CLEAR_FLAGS = 1'b0;
    wc_load                 = 1'b0;
    wc_val                  = SETTLE_VAL;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (START) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        DELAY_LINE_LOAD = 1'b1;
        wc_load         = 1'b1;
        state_nxt       = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (wc_tc) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        EYE_MONITOR_CLEAR_FLAGS = 1'b1;
        wc_load                 = 1'b1;
        wc_val                  = SAMPLE_VAL;
        state_nxt               = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (wc_tc) state_nxt = ST_EVAL;
      end
      ST_EVAL: begin
        if (!sweep_last) begin
          state_nxt = ST_STEP;
        end else if (!win_ok) begin
          // No usable window: park the delay line back at tap 0.
          DELAY_LINE_LOAD = 1'b1;
          state_nxt       = ST_DONE;
        end else if (cur_tap == centre_nxt) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_CMOVE;
        end
      end
      ST_STEP: begin
        DELAY_LINE_MOVE = 1'b1;
        wc_load         = 1'b1;
        state_nxt       = ST_SETTLE;
      end
      ST_CMOVE: begin
        DELAY_LINE_MOVE      = 1'b1;
        DELAY_LINE_DIRECTION = 1'b0;
        wc_load              = 1'b1;
        state_nxt            = ST_CSETTLE;
      end
      ST_CSETTLE: begin
        if (wc_tc) state_nxt = (cur_tap == centre_q) ? ST_DONE : ST_CMOVE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      cur_tap    <= '0;
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
      centre_q   <= '0;
      sticky     <= 1'b0;
      oor_tap    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      if (start_ok) begin
        cur_tap    <= '0;
        cur_start  <= '0;
        cur_len    <= '0;
        best_start <= '0;
        best_len   <= '0;
        oor_tap    <= 1'b0;
        fail_q     <= 1'b0;
      end
      case (state)
        ST_SETTLE: if (DELAY_LINE_OUT_OF_RANGE) oor_tap <= 1'b1;
        ST_CLEAR:  sticky <= 1'b0;
        ST_SAMPLE: sticky <= sticky | EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
        ST_EVAL: begin
          cur_len    <= len_upd;
          cur_start  <= start_upd;
          best_len   <= best_len_upd;
          best_start <= best_start_upd;
          centre_q   <= centre_nxt;
          if (sweep_last && !win_ok) begin
            fail_q  <= 1'b1;
            cur_tap <= '0;
          end
        end
        ST_STEP: begin
          cur_tap <= cur_tap + TAP_W'(1);
          oor_tap <= 1'b0;
        end
        ST_CMOVE: cur_tap <= cur_tap - TAP_W'(1);
        default: ;
      endcase
    end
  end

`ifdef IOD_TRAIN_STATUS_EN
  logic [TAP_W-1:0] sweep_end_q;
  logic [15:0]      fail_taps_q;

  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      sweep_end_q <= '0;
      fail_taps_q <= '0;
    end else if (start_ok) begin
      sweep_end_q <= '0;
      fail_taps_q <= '0;
    end else if (state == ST_EVAL) begin
      if (sweep_last) sweep_end_q <= cur_tap;
      if (!pass && fail_taps_q != 16'hFFFF) fail_taps_q <= fail_taps_q + 16'd1;
    end
  end

  assign WIN_START = best_start;
  assign SWEEP_END = sweep_end_q;
  assign FAIL_TAPS = fail_taps_q;
`endif

  assign BUSY    = (state != ST_IDLE) && (state != ST_DONE);
  assign DONE    = (state == ST_DONE);
  assign FAIL    = fail_q;
  assign TAP_OUT = cur_tap;
  assign WIN_LEN = best_len;

endmodule

// File: tb/tb_iod_read_training_ctrl.sv
// Scoreboard bench for iod_read_training_ctrl: a delay-line / eye-monitor
// model drives the flags from a per-tap pass map, the expected result of each
// sweep is derived from the pass map's maximal runs and queued at START, and
// a monitor compares against the DUT whenever DONE rises.
module tb_iod_read_training_ctrl;

  localparam int TAP_W         = 8;
  localparam int MAX_TAPS      = 128;
  localparam int SETTLE_CYCLES = 4;
  localparam int SAMPLE_CYCLES = 16;
  localparam int MIN_WINDOW    = 4;
  localparam int MAX_WAIT      = 8000;

  logic             clk = 1'b0;
  logic             rst, start;
  logic             busy, done, fail;
  logic [TAP_W-1:0] tap_out;
  logic [TAP_W:0]   win_len;
  logic             load, move, dir, clr;
  logic             early, late, oor;

  always #5 clk = ~clk;

  iod_read_training_ctrl #(
    .TAP_W(TAP_W), .MAX_TAPS(MAX_TAPS), .SETTLE_CYCLES(SETTLE_CYCLES),
    .SAMPLE_CYCLES(SAMPLE_CYCLES), .MIN_WINDOW(MIN_WINDOW)
  ) dut (
    .FAB_CLK                 (clk),
    .RX_SYNC_RST             (rst),
    .START                   (start),
    .BUSY                    (busy),
    .DONE                    (done),
    .FAIL                    (fail),
    .TAP_OUT                 (tap_out),
    .WIN_LEN                 (win_len),
    .DELAY_LINE_LOAD         (load),
    .DELAY_LINE_MOVE         (move),
    .DELAY_LINE_DIRECTION    (dir),
    .EYE_MONITOR_CLEAR_FLAGS (clr),
    .EYE_MONITOR_EARLY       (early),
    .EYE_MONITOR_LATE        (late),
    .DELAY_LINE_OUT_OF_RANGE (oor)
  );

  typedef struct {
    int tap; int len; int fail; int ups; int downs; int loads;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // scenario knobs
  bit   pass_map [MAX_TAPS];
  int   oor_at;
  bit   stuck;
  bit   noise_en;

  // delay-line / eye-monitor model state
  int   pos, win, hit, ups, downs, loads, multi;
  bit   sel, done_q;
  int   n, s0, l0, s1, l1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected result from the maximal passing runs of the swept taps.
  function automatic exp_t ref_model();
    int   rs[$];
    int   rl[$];
    int   end_t, cur, best, bs, c;
    exp_t e;
    end_t = (oor_at < MAX_TAPS) ? oor_at : MAX_TAPS - 1;
    cur = 0;
    for (int t = 0; t <= end_t; t++) begin
      bit p;
      p = !stuck && pass_map[t] && (t < oor_at);
      if (p) cur++;
      if ((!p || t == end_t) && cur > 0) begin
        rs.push_back(p ? t - cur + 1 : t - cur);
        rl.push_back(cur);
        cur = 0;
      end
    end
    best = 0;
    bs   = 0;
    foreach (rl[i]) if (rl[i] > best) begin best = rl[i]; bs = rs[i]; end
    e.len = best;
    e.ups = end_t;
    if (best < MIN_WINDOW) begin
      e.fail = 1; e.tap = 0; e.downs = 0; e.loads = 2;
    end else begin
      c = bs + (best - 1) / 2;
      e.fail = 0; e.tap = c; e.downs = end_t - c; e.loads = 1;
    end
    return e;
  endfunction

  task automatic set_windows(input int a0, input int b0, input int a1, input int b1);
    for (int t = 0; t < MAX_TAPS; t++)
      pass_map[t] = ((t >= a0 && t <= b0) || (a1 >= 0 && t >= a1 && t <= b1));
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic start_sweep();
    bit was_done;
    was_done = done;
    sb_q.push_back(ref_model());
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    if (was_done) chk("done_drop_on_start", int'(done), 0);
  endtask

  task automatic wait_done(input bit poke);
    n = 0;
    while (!done && n < MAX_WAIT) begin
      @(posedge clk); #1;
      start = (poke && busy && $urandom_range(150, 0) == 0);
      n++;
    end
    start = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got busy=%0d expected done within %0d cycles", busy, MAX_WAIT);
      sb_q.delete();
      pulse_reset();
    end
  endtask

  task automatic run(input bit poke);
    start_sweep();
    wait_done(poke);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; early = 1'b0; late = 1'b0; oor = 1'b0;
    oor_at = 1000; stuck = 1'b0; noise_en = 1'b1;
    pos = 0; win = 0; hit = 0; ups = 0; downs = 0; loads = 0; multi = 0;
    done_q = 1'b0;
    set_windows(-1, -1, -1, -1);
    fork
      begin : stimulus
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_tap_out", int'(tap_out), 0);
        chk("rst_win_len", int'(win_len), 0);
        chk("rst_load", int'(load), 0);
        chk("rst_move", int'(move), 0);
        chk("rst_clear", int'(clr), 0);
        chk("rst_direction", int'(dir), 1);

        set_windows(20, 59, -1, -1);
        run(1'b0);
        set_windows(10, 19, 70, 99);
        run(1'b1);
        set_windows(10, 29, 70, 89);
        run(1'b1);
        set_windows(-1, -1, -1, -1);
        stuck = 1'b1;
        run(1'b0);
        stuck = 1'b0;
        set_windows(30, 49, -1, -1);
        oor_at = 50;
        run(1'b0);
        oor_at = 1000;

        // reset in the middle of the sample window at tap 5
        set_windows(20, 59, -1, -1);
        start_sweep();
        n = 0;
        while (!(pos == 5 && win > 0 && win < SAMPLE_CYCLES) && n < MAX_WAIT) begin
          @(posedge clk); #1;
          n++;
        end
        chk("reached_tap5_sample", int'(pos == 5 && win > 0), 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        void'(sb_q.pop_back());
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_pulses", int'(load) + int'(move) + int'(clr), 0);
        chk("midrst_tap_out", int'(tap_out), 0);
        run(1'b0);

        for (int r = 0; r < 3; r++) begin
          s0 = $urandom_range(60, 0);  l0 = $urandom_range(30, 1);
          s1 = $urandom_range(126, 60); l1 = $urandom_range(30, 1);
          if (s1 + l1 > MAX_TAPS) l1 = MAX_TAPS - s1;
          set_windows(s0, s0 + l0 - 1, s1, s1 + l1 - 1);
          run(1'b1);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
      end
      begin : monitor
        forever begin
          @(negedge clk);
          if (done && !done_q) begin
            if (sb_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done: got done with tap_out=%0d, expected no result", tap_out);
            end else begin
              mon_e = sb_q.pop_front();
              chk("tap_out", int'(tap_out), mon_e.tap);
              chk("win_len", int'(win_len), mon_e.len);
              chk("fail", int'(fail), mon_e.fail);
              chk("busy_in_done", int'(busy), 0);
              chk("inc_moves", ups, mon_e.ups);
              chk("dec_moves", downs, mon_e.downs);
              chk("loads", loads, mon_e.loads);
              chk("delay_line_pos", pos, mon_e.tap);
              chk("pulse_exclusive", multi, 0);
            end
          end
          done_q = done;
        end
      end
      begin : line_model
        forever begin
          @(negedge clk);
          if (start && !busy) begin ups = 0; downs = 0; loads = 0; multi = 0; end
          if (int'(load) + int'(move) + int'(clr) > 1) multi++;
          if (load) begin loads++; pos = 0; end
          if (move) begin
            if (dir) begin ups++; pos++; end
            else begin downs++; pos--; end
          end
          oor = (pos >= oor_at);
          if (clr) begin
            win   = SAMPLE_CYCLES;
            hit   = $urandom_range(SAMPLE_CYCLES - 1, 0);
            sel   = $urandom_range(1, 0);
            early = stuck | (noise_en & $urandom_range(1, 0));
            late  = noise_en & $urandom_range(1, 0);
          end else if (win > 0) begin
            if (stuck || pos < 0 || pos >= MAX_TAPS || pos >= oor_at || !pass_map[pos]) begin
              early = stuck | ((SAMPLE_CYCLES - win) == hit && sel);
              late  = ((SAMPLE_CYCLES - win) == hit && !sel);
            end else begin
              early = 1'b0;
              late  = 1'b0;
            end
            win--;
          end else begin
            early = stuck | (noise_en & $urandom_range(1, 0));
            late  = noise_en & $urandom_range(1, 0);
          end
        end
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iod_read_training_ctrl.md
# iod_read_training_ctrl

Per-lane read-training sequencer for the DDR4 PHY's IOD read-training lane. It sweeps the IOD receive delay line tap by tap and samples the eye-monitor EARLY/LATE flags at each tap. It finds the widest passing window and parks the delay line at that window's centre. It sits in the fabric clock domain between the training master and one lane IOD, and drives that IOD's dynamic delay-line and eye-monitor controls.

## Interface
Parameters:
- TAP_W, 8: width of tap counters.
- MAX_TAPS, 128: number of taps swept (0..MAX_TAPS-1); must be ≤ 2^TAP_W.
- SETTLE_CYCLES, 4: wait after any LOAD/MOVE before clearing flags.
- SAMPLE_CYCLES, 16: eye-monitor observation time per tap.
- MIN_WINDOW, 4: minimum passing-window width for success.

Ports:
- FAB_CLK  in  1  fabric clock; all logic on its rising edge.
- RX_SYNC_RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle request; honoured only in IDLE or DONE.
- BUSY  out  1  high from the cycle after START until DONE.
- DONE  out  1  level; held until the next accepted START or reset.
- FAIL  out  1  valid with DONE; best window < MIN_WINDOW.
- TAP_OUT  out  TAP_W  final tap; valid with DONE.
- WIN_LEN  out  TAP_W+1  best window width; valid with DONE.
- DELAY_LINE_LOAD  out  1  one-cycle pulse; returns the delay line to tap 0.
- DELAY_LINE_MOVE  out  1  one-cycle pulse; one-tap step.
- DELAY_LINE_DIRECTION  out  1  1 = increment, 0 = decrement; stable in every MOVE cycle.
- EYE_MONITOR_CLEAR_FLAGS  out  1  one-cycle pulse.
- EYE_MONITOR_EARLY, EYE_MONITOR_LATE  in  1 each  IOD eye-monitor flags.
- DELAY_LINE_OUT_OF_RANGE  in  1  IOD delay-line limit flag.

## Operation
- States: IDLE, LOAD, SETTLE, CLEAR, SAMPLE, EVAL, STEP, CMOVE, CSETTLE, DONE.
- IDLE/DONE, START=1 → LOAD. This clears DONE, FAIL, window registers and cur_tap=0.
- LOAD: DELAY_LINE_LOAD pulse → SETTLE.
- SETTLE (SETTLE_CYCLES) → CLEAR.
  - If DELAY_LINE_OUT_OF_RANGE is seen during SETTLE, the tap is marked failing and last_tap is set.
- CLEAR: EYE_MONITOR_CLEAR_FLAGS pulse → SAMPLE.
- SAMPLE (SAMPLE_CYCLES): sticky OR of EARLY|LATE → EVAL.
- EVAL, single cycle:
  - pass = !sticky && !oor.
  - On pass: cur_len++ (cur_start=cur_tap if cur_len was 0).
  - On fail: cur_len=0.
  - If cur_len (post-update) > best_len, best := cur; strictly greater, so ties keep the earlier window.
  - If last_tap or cur_tap==MAX_TAPS-1 → centre phase. Otherwise → STEP.
- STEP: MOVE pulse with DIRECTION=1; cur_tap++ → SETTLE.
- Centre phase:
  - If best_len < MIN_WINDOW: FAIL=1, LOAD pulse, TAP_OUT=0 → DONE.
  - Otherwise centre = best_start + (best_len-1)>>1 (floor), and the block issues cur_tap−centre decrement MOVEs.
  - CMOVE: MOVE pulse with DIRECTION=0 and cur_tap--, then CSETTLE (SETTLE_CYCLES). Repeat until cur_tap==centre → DONE.
  - If cur_tap==centre already, go straight to DONE.
- DONE: DONE=1, BUSY=0, TAP_OUT=cur_tap, WIN_LEN=best_len.
- START while BUSY is ignored. EARLY/LATE outside SAMPLE are ignored.

## Timing
- Reset values: BUSY=0, DONE=0, FAIL=0, TAP_OUT=0, WIN_LEN=0, all pulses 0, DIRECTION=1, state IDLE.
- Reset mid-operation: outputs return to reset values on the next edge. No LOAD is issued; the next START reloads the delay line.
- Tap 0 costs SETTLE+SAMPLE+3 cycles including LOAD. Every further tap costs SETTLE+SAMPLE+3 cycles (STEP, SETTLE, CLEAR, SAMPLE, EVAL).
- Each centring step costs 1+SETTLE_CYCLES cycles.
- Full sweep at defaults: 128×23 = 2944 cycles plus centring.
- At most one of LOAD, MOVE or CLEAR_FLAGS is high in any cycle.

## Configuration
- IOD_TRAIN_STATUS_EN defined:
  - Adds outputs WIN_START (TAP_W, best_start) and SWEEP_END (TAP_W, last tap evaluated), both valid with DONE and reset to 0.
  - Adds a 16-bit saturating count of failing taps on FAIL_TAPS.
- Undefined: these ports and registers are absent. Behaviour is otherwise identical.

## Structure
- Shared package iod_train_pkg holds the state enum, the default parameter constants, and a centre-compute function.
- One sub-module, iod_train_wait_cnt: a loadable down-counter shared by SETTLE, SAMPLE and CSETTLE. It has a terminal-count output.

## Test plan
- Bench delay-line model passes taps 20..59 → 128 taps swept; 88 MOVEs with DIRECTION=0; DONE with TAP_OUT=39, WIN_LEN=40, FAIL=0.
- Passing windows 10..19 and 70..99 → WIN_LEN=30, TAP_OUT=84. A tie variant (10..29, 70..89) gives TAP_OUT=19.
- No passing tap (EARLY stuck high) → FAIL=1, exactly one LOAD after sweep, TAP_OUT=0, WIN_LEN=0.
- Window 30..49, OUT_OF_RANGE asserted after the MOVE to tap 50 → sweep ends at 50; 11 decrement MOVEs; TAP_OUT=39.
- RX_SYNC_RST pulsed mid-SAMPLE at tap 5 → next cycle BUSY=0, no pulses. A following START restarts with LOAD and re-sweeps from tap 0.
- START pulsed while BUSY → ignored, result unchanged. START in DONE → DONE drops the next cycle and a new sweep begins.
